// File: rtl/fft_r4_bfly.sv
// rtl/fft_r4_bfly.sv - radix-4 DIF butterfly with per-beat twiddle, 3-stage pipeline
module fft_r4_bfly (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [135:0] data_in,
  input  logic         in_valid,
  output logic [135:0] data_out,
  output logic         out_valid,
  output logic         frame_start
);

  logic [1:0]         beat;
  logic               s1_valid;
  logic               s2_valid;
  logic [1:0]         s1_beat;
  logic [1:0]         s2_beat;
  logic [135:0]       s1_data;
  logic signed [16:0] s2_re [4];
  logic signed [16:0] s2_im [4];

  logic signed [18:0] xr [4];
  logic signed [18:0] xi [4];
  logic signed [18:0] br [4];
  logic signed [18:0] bi [4];

  logic [3:0]         m  [4];
  logic signed [16:0] cr [4];
  logic signed [16:0] ci [4];
  logic signed [35:0] pr [4];
  logic signed [35:0] pi [4];
  logic signed [35:0] rr [4];
  logic signed [35:0] ri [4];
  logic [135:0]       tw_out;

  function automatic logic signed [16:0] tw_re(input logic [3:0] idx);
    case (idx)
      4'd0:    return 17'sd32768;
      4'd1:    return 17'sd30274;
      4'd2:    return 17'sd23170;
      4'd3:    return 17'sd12540;
      4'd4:    return 17'sd0;
      4'd6:    return -17'sd23170;
      4'd9:    return -17'sd30274;
      default: return 17'sd0;
    endcase
  endfunction

  function automatic logic signed [16:0] tw_im(input logic [3:0] idx);
    case (idx)
      4'd0:    return 17'sd0;
      4'd1:    return -17'sd12540;
      4'd2:    return -17'sd23170;
      4'd3:    return -17'sd30274;
      4'd4:    return -17'sd32768;
      4'd6:    return -17'sd23170;
      4'd9:    return 17'sd12540;
      default: return 17'sd0;
    endcase
  endfunction

  function automatic logic [16:0] sat17(input logic signed [35:0] v);
    if (v > 36'sd65535)
      return 17'h0ffff;
    else if (v < -36'sd65536)
      return 17'h10000;
    else
      return v[16:0];
  endfunction

  // Control path: only the beat counter and valid bits need reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= 2'd0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      if (in_valid)
        beat <= beat + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xr[i] = {{2{s1_data[34*i+33]}}, s1_data[34*i+17 +: 17]};
      xi[i] = {{2{s1_data[34*i+16]}}, s1_data[34*i +: 17]};
    end
    br[0] = xr[0] + xr[1] + xr[2] + xr[3];
    bi[0] = xi[0] + xi[1] + xi[2] + xi[3];
    br[1] = xr[0] + xi[1] - xr[2] - xi[3];
    bi[1] = xi[0] - xr[1] - xi[2] + xr[3];
    br[2] = xr[0] - xr[1] + xr[2] - xr[3];
    bi[2] = xi[0] - xi[1] + xi[2] - xi[3];
    br[3] = xr[0] - xi[1] - xr[2] + xi[3];
    bi[3] = xi[0] + xr[1] - xi[2] - xr[3];
  end

  // Data path registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_data <= data_in;
      s1_beat <= beat;
    end
    if (s1_valid) begin
      s2_beat <= s1_beat;
      for (int k = 0; k < 4; k++) begin
        s2_re[k] <= br[k][18:2];
        s2_im[k] <= bi[k][18:2];
      end
    end
  end

  always_comb begin
    tw_out = '0;
    for (int k = 0; k < 4; k++) begin
      m[k]  = 4'(k) * {2'b00, s2_beat};
      cr[k] = tw_re(m[k]);
      ci[k] = tw_im(m[k]);
      pr[k] = 36'(s2_re[k]) * 36'(cr[k]) - 36'(s2_im[k]) * 36'(ci[k]);
      pi[k] = 36'(s2_re[k]) * 36'(ci[k]) + 36'(s2_im[k]) * 36'(cr[k]);
      rr[k] = (pr[k] + 36'sd16384) >>> 15;
      ri[k] = (pi[k] + 36'sd16384) >>> 15;
      tw_out[34*k +: 34] = {sat17(rr[k]), sat17(ri[k])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      out_valid   <= s2_valid;
      frame_start <= s2_valid && (s2_beat == 2'd0);
      if (s2_valid)
        data_out <= tw_out;
    end
  end

endmodule

// File: tb/tb_fft_r4_bfly.sv
// tb/tb_fft_r4_bfly.sv - directed self-checking bench for fft_r4_bfly
module tb_fft_r4_bfly;

  logic         clk;
  logic         rst_n;
  logic [135:0] data_in;
  logic         in_valid;
  logic [135:0] data_out;
  logic         out_valid;
  logic         frame_start;

  int checks = 0;
  int errors = 0;
  int pv [9] = '{1, 0, 1, 1, 0, 1, 0, 0, 0};
  int vv [9] = '{100, 0, 200, 300, 0, 400, 0, 0, 0};
  logic [135:0] last;
  logic [135:0] imp;

  fft_r4_bfly dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] cx(input int re, input int im);
    logic [16:0] r;
    logic [16:0] i;
    r = re[16:0];
    i = im[16:0];
    return {r, i};
  endfunction

  function automatic logic [135:0] p4(input logic [33:0] a, input logic [33:0] b,
                                      input logic [33:0] c, input logic [33:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [135:0] all4(input int v);
    return p4(cx(v, 0), cx(v, 0), cx(v, 0), cx(v, 0));
  endfunction

  function automatic logic [135:0] x0only(input int v);
    return p4(cx(v, 0), 34'd0, 34'd0, 34'd0);
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [135:0] d);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    imp      = p4(cx(1000, 0), 34'd0, 34'd0, 34'd0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_data_out", data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // impulse on beat 0
    step(1'b1, imp);
    step(1'b0, '0);
    chk("imp_ov_early", out_valid, 0);
    step(1'b0, '0);
    chk("imp_ov", out_valid, 1);
    chk("imp_fs", frame_start, 1);
    chk("imp_data", data_out, all4(250));

    // impulse on beat 1
    step(1'b1, imp);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("tw_ov", out_valid, 1);
    chk("tw_fs", frame_start, 0);
    chk("tw_data", data_out, p4(cx(250, 0), cx(231, -96), cx(177, -177), cx(96, -231)));

    // back-to-back saturation / full-scale beats 2,3,0,1,2
    step(1'b1, all4(0) | p4(cx(65535, -65536), cx(65535, -65536), cx(65535, -65536), cx(65535, -65536)));
    step(1'b1, '0);
    step(1'b1, '0);
    chk("fs_b2_data", data_out, p4(cx(65535, -65536), 34'd0, 34'd0, 34'd0));
    chk("fs_b2_fs", frame_start, 0);
    step(1'b1, p4(cx(65535, 65535), 34'd0, 34'd0, 34'd0));
    chk("zero_b3_data", data_out, 0);
    chk("zero_b3_ov", out_valid, 1);
    step(1'b1, p4(cx(-65536, 0), cx(65535, 0), cx(-65536, 0), cx(65535, 0)));
    chk("zero_b0_fs", frame_start, 1);
    step(1'b0, '0);
    chk("sat_b1_data", data_out,
        p4(cx(16383, 16383), cx(21406, 8866), cx(23169, 0), cx(21406, -8866)));
    step(1'b0, '0);
    chk("sat_m4_data", data_out, p4(cx(-1, 0), 34'd0, cx(0, 65535), 34'd0));
    step(1'b0, '0);
    chk("hold_ov", out_valid, 0);
    chk("hold_fs", frame_start, 0);
    chk("hold_data", data_out, p4(cx(-1, 0), 34'd0, cx(0, 65535), 34'd0));

    // realign to beat 0 and drain
    step(1'b1, '0);
    repeat (3) step(1'b0, '0);

    // 8 consecutive beats
    for (int i = 0; i < 10; i++) begin
      step(i < 8, all4(i + 1));
      if (i >= 2) begin
        chk("thr_ov", out_valid, 1);
        chk("thr_fs", frame_start, ((i - 2) % 4) == 0);
        chk("thr_data", data_out, x0only(i - 1));
      end
    end
    step(1'b0, '0);
    chk("thr_tail_ov", out_valid, 0);

    // gapped input 1,0,1,1,0,1
    last = '0;
    for (int i = 0; i < 9; i++) begin
      step(pv[i] != 0, all4(vv[i]));
      if (i >= 2) begin
        if (pv[i-2] != 0)
          last = x0only(vv[i-2]);
        chk("gap_ov", out_valid, pv[i-2] != 0);
        chk("gap_fs", frame_start, (i - 2) == 0);
        chk("gap_data", data_out, last);
      end
    end

    // mid-frame reset with beats in flight
    step(1'b1, all4(10));
    step(1'b1, all4(20));
    step(1'b1, all4(30));
    chk("pre_rst_ov", out_valid, 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_fs", frame_start, 0);
    chk("arst_data", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      chk("rst_flush_ov", out_valid, 0);
    end
    step(1'b1, all4(50));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("post_rst_ov", out_valid, 1);
    chk("post_rst_fs", frame_start, 1);
    chk("post_rst_data", data_out, x0only(50));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
